// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment display path.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam int         DIGIT_W   = 3;

    // Entry n lives at bits [7n+6:7n]; digit F is the leftmost word.
    localparam logic [16*7-1:0] HEX_LUT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] hex_seg(input logic [3:0] nib);
        return HEX_LUT[7*nib +: 7];
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Nibble to active-low 7-segment pattern, with a blanking override.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] i_nib,
    input  logic       i_blank,
    output logic [6:0] o_seg_n
);

    assign o_seg_n = i_blank ? SEG_BLANK : hex_seg(i_nib);

endmodule

// File: rtl/outport_seg_scanner.sv
// Captures the CPU output port and scans it onto a multiplexed
// common-anode hex display with leading-zero blanking.
module outport_seg_scanner
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 50000,
    parameter int GUARD      = 2,
    parameter int LZB        = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           outport_data,
    input  logic                  load,
    input  logic                  blank,
    output logic [NUM_DIGITS-1:0] an_n,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic                  changed
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int VIS_W = 4 * NUM_DIGITS;

    logic [31:0]           r_held;
    logic [CNT_W-1:0]      r_cnt;
    logic [DIGIT_W-1:0]    r_idx;
    logic [NUM_DIGITS-1:0] r_an_n;
    logic [6:0]            r_seg_n;
    logic                  r_changed;

    logic [VIS_W-1:0]      w_vis;
    logic [3:0]            w_nib;
    logic                  w_hi_zero;
    logic                  w_dig_blank;
    logic                  w_wrap;
    logic                  w_an_off;
    logic [6:0]            w_seg_n;

    assign w_vis       = r_held[VIS_W-1:0];
    assign w_nib       = w_vis[{r_idx, 2'b00} +: 4];
    assign w_hi_zero   = (w_vis >> {r_idx, 2'b00}) == '0;
    assign w_dig_blank = (LZB != 0) && (r_idx != '0) && w_hi_zero;
    assign w_wrap      = (r_cnt == CNT_W'(SCAN_DIV - 1));
    // Anodes stay dark for the guard band so segments settle first.
    assign w_an_off    = blank || (r_cnt < CNT_W'(GUARD)) || w_dig_blank;

    hex_to_seg7 u_dec (
        .i_nib   (w_nib),
        .i_blank (blank | w_dig_blank),
        .o_seg_n (w_seg_n)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
            r_idx <= (r_idx == DIGIT_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_held    <= '0;
            r_changed <= 1'b0;
        end else if (load) begin
            r_held    <= outport_data;
            r_changed <= (outport_data != r_held);
        end else begin
            r_changed <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_an_n  <= '1;
            r_seg_n <= SEG_BLANK;
        end else begin
            r_an_n  <= w_an_off ? '1 : ~(NUM_DIGITS'(1) << r_idx);
            r_seg_n <= w_seg_n;
        end
    end

    assign an_n    = r_an_n;
    assign seg_n   = r_seg_n;
    assign dp_n    = 1'b1;
    assign changed = r_changed;

endmodule

// File: tb/tb_outport_seg_scanner.sv
// Randomised bench for outport_seg_scanner against a time-based
// model: digit = (cycles/SCAN_DIV) mod NUM_DIGITS.
module tb_outport_seg_scanner;

    localparam int SD = 4;
    localparam int GD = 1;
    localparam int ND = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load = 1'b0;
    logic        blank = 1'b0;
    logic [31:0] data = '0;
    logic [7:0]  an_n;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic        changed;

    always #5 clk = ~clk;

    outport_seg_scanner #(
        .NUM_DIGITS (ND),
        .SCAN_DIV   (SD),
        .GUARD      (GD),
        .LZB        (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .outport_data (data),
        .load         (load),
        .blank        (blank),
        .an_n         (an_n),
        .seg_n        (seg_n),
        .dp_n         (dp_n),
        .changed      (changed)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] m_held;
    int          m_t;
    logic [7:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_chg;

    logic [6:0] hex_tab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Predict the outputs of the coming edge, advance the model, clock.
    task automatic tick();
        int slot, dig, pos;
        logic [31:0] up;
        logic dbl;
        slot  = m_t / SD;
        dig   = slot % ND;
        pos   = m_t % SD;
        up    = m_held >> (4 * dig);
        dbl   = (dig != 0) && (up == 0);
        e_an  = (blank || pos < GD || dbl) ? 8'hFF : ~(8'h01 << dig);
        e_seg = (blank || dbl) ? 7'h7F : hex_tab[up[3:0]];
        e_chg = load && (data != m_held);
        if (load) m_held = data;
        m_t++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            load = 1'($urandom);
            data = $urandom;
            @(posedge clk);
            #1;
            n_checks++;
            if ({an_n, seg_n, changed, dp_n} !== {8'hFF, 7'h7F, 1'b0, 1'b1})
                $display("FAIL reset_hold: an=%h seg=%h chg=%b dp=%b want FF/7F/0/1",
                         an_n, seg_n, changed, dp_n);
            else n_pass++;
        end
        load   = 1'b0;
        reset  = 1'b1;
        m_t    = 0;
        m_held = '0;
        for (int i = 0; i < 2 * SD; i++) begin
            tick();
            n_checks++;
            if ({an_n, seg_n, changed, dp_n} !== {e_an, e_seg, e_chg, 1'b1})
                $display("FAIL reset_release[%0d]: an=%h seg=%h chg=%b dp=%b want %h/%h/%b/1",
                         i, an_n, seg_n, changed, dp_n, e_an, e_seg, e_chg);
            else n_pass++;
            if (i == 1) begin
                n_checks++;
                if (an_n !== 8'hFE)
                    $display("FAIL first_anode: an=%h want FE", an_n);
                else n_pass++;
            end
        end
    endtask

    task automatic test_scan_walk();
        data = 32'h12345678;
        load = 1'b1;
        tick();
        load = 1'b0;
        n_checks++;
        if (changed !== 1'b1)
            $display("FAIL walk_changed: chg=%b want 1", changed);
        else n_pass++;
        tick();
        n_checks++;
        if (changed !== 1'b0)
            $display("FAIL walk_changed_once: chg=%b want 0", changed);
        else n_pass++;
        for (int i = 0; i < 2 * ND * SD; i++) begin
            tick();
            n_checks++;
            if ({an_n, seg_n, changed} !== {e_an, e_seg, e_chg})
                $display("FAIL walk[%0d]: an=%h seg=%h chg=%b want %h/%h/%b",
                         i, an_n, seg_n, changed, e_an, e_seg, e_chg);
            else n_pass++;
        end
    endtask

    task automatic test_lzb();
        logic [31:0] vals [2];
        vals[0] = 32'h0000_00A0;
        vals[1] = 32'h0;
        for (int v = 0; v < 2; v++) begin
            data = vals[v];
            load = 1'b1;
            tick();
            load = 1'b0;
            for (int i = 0; i < ND * SD + 2; i++) begin
                tick();
                n_checks++;
                if ({an_n, seg_n, changed} !== {e_an, e_seg, e_chg})
                    $display("FAIL lzb[%0d][%0d]: an=%h seg=%h chg=%b want %h/%h/%b",
                             v, i, an_n, seg_n, changed, e_an, e_seg, e_chg);
                else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] seq [4];
        logic [3:0]  want;
        seq[0] = 32'hDEADBEEF;
        seq[1] = 32'hDEADBEEF;
        seq[2] = 32'hDEADBEEF;
        seq[3] = 32'hDEADBEEE;
        want   = 4'b1001;
        load   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data = seq[i];
            tick();
            n_checks++;
            if ({changed, an_n, seg_n} !== {want[3-i], e_an, e_seg})
                $display("FAIL b2b[%0d]: chg=%b an=%h seg=%h want %b/%h/%h",
                         i, changed, an_n, seg_n, want[3-i], e_an, e_seg);
            else n_pass++;
        end
        load = 1'b0;
    endtask

    task automatic test_blank();
        blank = 1'b1;
        for (int i = 0; i < 10 * SD; i++) begin
            tick();
            n_checks++;
            if ({an_n, seg_n} !== {8'hFF, 7'h7F} || {an_n, seg_n} !== {e_an, e_seg})
                $display("FAIL blank[%0d]: an=%h seg=%h want FF/7F", i, an_n, seg_n);
            else n_pass++;
        end
        blank = 1'b0;
        for (int i = 0; i < ND * SD; i++) begin
            tick();
            n_checks++;
            if ({an_n, seg_n, changed} !== {e_an, e_seg, e_chg})
                $display("FAIL unblank[%0d]: an=%h seg=%h chg=%b want %h/%h/%b",
                         i, an_n, seg_n, changed, e_an, e_seg, e_chg);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            load  = ($urandom_range(0, 3) == 0);
            data  = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 3) == 0) data = m_held;
            blank = ($urandom_range(0, 15) == 0);
            tick();
            n_checks++;
            if ({an_n, seg_n, changed, dp_n} !== {e_an, e_seg, e_chg, 1'b1})
                $display("FAIL random[%0d]: an=%h seg=%h chg=%b dp=%b want %h/%h/%b/1",
                         i, an_n, seg_n, changed, dp_n, e_an, e_seg, e_chg);
            else n_pass++;
        end
        load  = 1'b0;
        blank = 1'b0;
    endtask

    task automatic test_reset_mid();
        int guard_cnt;
        data = 32'h89ABCDEF;
        load = 1'b1;
        tick();
        load = 1'b0;
        guard_cnt = 0;
        while (!(((m_t / SD) % ND) == 3 && (m_t % SD) == 2) && guard_cnt < 64) begin
            tick();
            guard_cnt++;
        end
        n_checks++;
        if (guard_cnt >= 64 || an_n !== 8'hF7)
            $display("FAIL mid_slot3_setup: an=%h want F7 (waited %0d)", an_n, guard_cnt);
        else n_pass++;
        #1;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({an_n, seg_n, changed} !== {8'hFF, 7'h7F, 1'b0})
            $display("FAIL async_reset: an=%h seg=%h chg=%b want FF/7F/0",
                     an_n, seg_n, changed);
        else n_pass++;
        @(posedge clk);
        #1;
        reset  = 1'b1;
        m_t    = 0;
        m_held = '0;
        for (int i = 0; i < ND * SD; i++) begin
            tick();
            n_checks++;
            if ({an_n, seg_n, changed} !== {e_an, e_seg, e_chg})
                $display("FAIL after_reset[%0d]: an=%h seg=%h chg=%b want %h/%h/%b",
                         i, an_n, seg_n, changed, e_an, e_seg, e_chg);
            else n_pass++;
        end
    endtask

    initial begin
        m_t    = 0;
        m_held = '0;
        test_reset();
        test_scan_walk();
        test_lzb();
        test_back_to_back();
        test_blank();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/outport_seg_scanner.md
Name: outport_seg_scanner

Overview:
- Consumes the CPU datapath's 32-bit `outport_data` and drives a multiplexed, common-anode 7-segment display bank showing the value as hexadecimal.
- Sits directly downstream of the datapath's output port, at the top level beside the CPU.
- Holds a captured copy of the port value and scans one digit per time slot.
- Provides leading-zero blanking, an anti-ghost guard band and a change-detect pulse.

Parameters:
- NUM_DIGITS, 8: number of displayed digits. Range 1..8; digit i shows nibble [4i+3:4i].
- SCAN_DIV, 50000: clock cycles per digit slot. Must be >= GUARD+2.
- GUARD, 2: cycles at the start of each slot during which all anodes are off.
- LZB, 1: 1 = blank leading zero digits; digit 0 is never blanked.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- outport_data  in  32  value from the datapath output port.
- load  in  1  when high, capture `outport_data` at this edge. The top level ties it high for continuous tracking.
- blank  in  1  forces all anodes off while high.
- an_n  out  NUM_DIGITS  digit enables, active-low, one-hot-cold.
- seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp_n  out  1  decimal point, active-low. Held at 1 (off).
- changed  out  1  one-cycle pulse when a load captures a value different from the held value.

Behaviour:
- Reset (reset=0, asynchronous):
  - held value = 0, slot counter = 0, digit index = 0.
  - an_n = all 1s, seg_n = 7'h7F, dp_n = 1, changed = 0.
  - Release is synchronous to the next clk edge.
- Capture:
  - If load=1 at an edge, held <= outport_data. `changed` is registered at that same edge: 1 iff outport_data != held (old value), else 0.
  - If load=0, held is kept and changed <= 0.
  - A new value is visible on seg_n no earlier than the next scan of that digit.
- Scan counter:
  - cnt counts 0..SCAN_DIV-1 and wraps to 0.
  - On wrap, idx <= (idx == NUM_DIGITS-1) ? 0 : idx+1.
  - idx wraps from NUM_DIGITS-1 to 0. There are no idle states.
- Digit blank qualifier (combinational from held and idx):
  - LZB=1 and idx != 0 and held[4*NUM_DIGITS-1 : 4*idx] == 0 → digit blank.
- Outputs (registered; they reflect the cnt/idx/held state of the previous cycle, so latency is 1 cycle):
  - an_n: all 1s if blank=1, or cnt < GUARD, or the digit is blank. Otherwise only bit idx = 0.
  - seg_n: 7'h7F if the digit is blank or blank=1. Otherwise hex decode of nibble idx.
  - seg_n is valid throughout the slot, including the guard cycles, so the segments settle before the anode turns on.
- Hex decode, active-low gfedcba:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex)
- Simultaneous events:
  - A load on the same edge as a slot wrap: the new idx decodes from the new held value on the following cycle.
  - `blank` does not stop the counter.
- Reset mid-slot: all state returns to reset values immediately; scanning restarts at digit 0, cnt 0.
- NUM_DIGITS < 8: upper outport_data bits are captured but not displayed. They still affect `changed`.

Decomposition:
- Shared package `seg7_pkg`:
  - SEG_BLANK constant (7'h7F).
  - 16-entry hex-to-segment constant table or function.
  - DIGIT_W constant (3).
- Sub-module `hex_to_seg7`: combinational, 4-bit nibble plus blank in → 7-bit seg_n out. One instance, driven by the muxed nibble.
- Everything else is inline: counter, index, capture, LZB, output registers.

Test Plan (SCAN_DIV=4, GUARD=1, NUM_DIGITS=8, LZB=1):
1. Hold reset=0 for 3 cycles while toggling load/outport_data → an_n=FF, seg_n=7F, changed=0 throughout. After release, the first slot's anode is active from cycle 2 of slot 0 (cnt ≥ 1, plus 1-cycle latency).
2. Load 32'h12345678 once, then load=0 → changed=1 for exactly one cycle. Over 8 slots, an_n walks FE,FD,…,7F, with seg_n 00(8),78(7),02(6),12(5),19(4),30(3),24(2),79(1). Pattern repeats after slot 7.
3. Load 32'h0000_00A0 → only digits 0 (seg 40) and 1 (seg 08) are enabled. an_n=FF in slots 2..7 (leading zeros blanked). Load 0 → only digit 0 shows 40.
4. Load 32'hDEADBEEF twice in consecutive cycles → changed pulses on the first only. Repeating with 32'hDEADBEEE on the second load gives two pulses.
5. Assert blank=1 for 10 slots → an_n=FF and seg_n=7F. idx keeps advancing: on deassert, scanning resumes at the digit matching elapsed slots mod 8.
6. Assert reset mid-slot 3 → an_n=FF in the same cycle (async). held=0: after release, digit 0 shows 40 and all others are blanked.
